// File: rtl/enc_edge_timestamper.sv
// Multi-channel encoder edge timestamper: per-channel 2-FF synchroniser and glitch filter,
// one pending slot per channel, a lowest-index-first arbiter into an event FIFO, AXI4-Stream out.
module enc_edge_timestamper #(
    parameter int N_CH       = 4,
    parameter int TS_WIDTH   = 48,
    parameter int FILT_LEN   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_CH-1:0]               enc_in,
    input  logic                          en,
    input  logic [2*N_CH-1:0]             edge_mode,
    input  logic                          ts_clear,
    output logic [63:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [TS_WIDTH-1:0]           ts_now,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   drop_count
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_CH-1:0]     filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [CW-1:0]       cnt_q [N_CH];
    logic [CW-1:0]       cnt_d [N_CH];
    logic [N_CH-1:0]     pend_q, pend_d, pol_q, pol_d, lost_q, lost_d;
    logic [TS_WIDTH-1:0] pts_q [N_CH];
    logic [TS_WIDTH-1:0] pts_d [N_CH];
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [31:0]         drop_q, drop_d;
    logic [63:0]         mem_q [FIFO_DEPTH];
    logic [63:0]         mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]       level_q, level_d;

    logic [N_CH-1:0]     rise_s, fall_s, qual_s, drop_s, wr_ch_s, take_s;
    logic                pop_s, push_s, found_s;
    logic [IW-1:0]       sel_s;
    logic [63:0]         word_s;
    logic [6:0]          drop_n_s;
    logic [32:0]         drop_sum_s;

    // Next-state logic for synchroniser, filter, capture, arbitration and FIFO.
    always_comb begin
        sync1_d     = enc_in;
        sync2_d     = sync1_q;
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        ts_d        = ts_clear ? {TS_WIDTH{1'b0}} : ts_q + TS_WIDTH'(1);

        // The counter only clears on agreement; once it has reached FILT_LEN the level flips.
        for (int c = 0; c < N_CH; c++) begin
            if (cnt_q[c] == CW'(FILT_LEN)) begin
                filt_d[c] = ~filt_q[c];
                cnt_d[c]  = {CW{1'b0}};
            end else if (sync2_q[c] != filt_q[c]) begin
                cnt_d[c]  = cnt_q[c] + CW'(1);
            end else begin
                cnt_d[c]  = {CW{1'b0}};
            end
        end

        rise_s = filt_q & ~filt_prev_q;
        fall_s = ~filt_q & filt_prev_q;
        for (int c = 0; c < N_CH; c++) begin
            qual_s[c] = en & ((rise_s[c] & edge_mode[2*c]) | (fall_s[c] & edge_mode[2*c+1]));
        end

        pop_s   = (level_q != LW'(0)) & m_axis_tready;
        found_s = 1'b0;
        sel_s   = {IW{1'b0}};
        for (int c = N_CH - 1; c >= 0; c--) begin
            found_s = found_s | pend_q[c];
            sel_s   = pend_q[c] ? IW'(c) : sel_s;
        end
        // A full FIFO still accepts a write when its head leaves in the same cycle.
        push_s = found_s & ((level_q != LW'(FIFO_DEPTH)) | pop_s);

        word_s                 = 64'd0;
        word_s[TS_WIDTH-1:0]   = pts_q[sel_s];
        word_s[56]             = pol_q[sel_s];
        word_s[62:57]          = 6'(sel_s);
        word_s[63]             = lost_q[sel_s];

        drop_n_s = 7'd0;
        for (int c = 0; c < N_CH; c++) begin
            wr_ch_s[c] = push_s & (sel_s == IW'(c));
            drop_s[c]  = qual_s[c] & pend_q[c];
            take_s[c]  = qual_s[c] & ~pend_q[c];
            pend_d[c]  = (pend_q[c] & ~wr_ch_s[c]) | take_s[c];
            pol_d[c]   = take_s[c] ? rise_s[c] : pol_q[c];
            pts_d[c]   = take_s[c] ? ts_q : pts_q[c];
            lost_d[c]  = (lost_q[c] & ~wr_ch_s[c]) | drop_s[c];
            drop_n_s   = drop_n_s + 7'(drop_s[c]);
        end
        drop_sum_s = {1'b0, drop_q} + 33'(drop_n_s);
        drop_d     = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];

        mem_d       = mem_q;
        mem_d[wr_q] = push_s ? word_s : mem_q[wr_q];
        wr_d        = push_s ? wr_q + AW'(1) : wr_q;
        rd_d        = pop_s ? rd_q + AW'(1) : rd_q;
        level_d     = level_q + LW'(push_s) - LW'(pop_s);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1_q     <= {N_CH{1'b0}};
            sync2_q     <= {N_CH{1'b0}};
            filt_q      <= {N_CH{1'b0}};
            filt_prev_q <= {N_CH{1'b0}};
            cnt_q       <= '{default: {CW{1'b0}}};
            pend_q      <= {N_CH{1'b0}};
            pol_q       <= {N_CH{1'b0}};
            lost_q      <= {N_CH{1'b0}};
            pts_q       <= '{default: {TS_WIDTH{1'b0}}};
            ts_q        <= {TS_WIDTH{1'b0}};
            drop_q      <= 32'd0;
            mem_q       <= '{default: 64'd0};
            wr_q        <= {AW{1'b0}};
            rd_q        <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pol_q       <= pol_d;
            lost_q      <= lost_d;
            pts_q       <= pts_d;
            ts_q        <= ts_d;
            drop_q      <= drop_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
        end
    end

    assign m_axis_tvalid = (level_q != LW'(0));
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_q] : 64'd0;
    assign ts_now        = ts_q;
    assign fifo_level    = level_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_enc_edge_timestamper.sv
// Self-checking bench for enc_edge_timestamper: queue-based event model checked every cycle,
// plus directed scenarios with hand-derived expectations.
`timescale 1ns/1ps
module tb_enc_edge_timestamper;

    localparam int NC  = 4;
    localparam int TSW = 8;
    localparam int FL  = 4;
    localparam int FD  = 16;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [NC-1:0]         enc_in = '0;
    logic                  en = 1'b0;
    logic [2*NC-1:0]       edge_mode = '0;
    logic                  ts_clear = 1'b0;
    logic                  m_axis_tready = 1'b1;
    logic [63:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic [TSW-1:0]        ts_now;
    logic [$clog2(FD):0]   fifo_level;
    logic [31:0]           drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_cyc = 0;

    enc_edge_timestamper #(.N_CH(NC), .TS_WIDTH(TSW), .FILT_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .aclk(aclk), .aresetn(aresetn), .enc_in(enc_in), .en(en), .edge_mode(edge_mode),
        .ts_clear(ts_clear), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .ts_now(ts_now), .fifo_level(fifo_level),
        .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    function automatic logic [63:0] mkword(input bit lost, input int ch, input bit pol, input int ts);
        logic [63:0] w;
        w = 64'd0;
        w[63] = lost;
        w[62:57] = 6'(ch);
        w[56] = pol;
        w[TSW-1:0] = TSW'(ts);
        return w;
    endfunction

    // Cycles since reset release; equals ts_now as long as ts_clear is untouched.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ref_cyc <= 0;
        else          ref_cyc <= ref_cyc + 1;
    end

    // Behavioural model: events flow from filtered toggles into per-channel slots, then a FIFO queue.
    logic [63:0]     fq[$];
    logic [NC-1:0]   m_hist[$];
    logic [NC-1:0]   m_synced;
    bit              m_pend[NC], m_pol[NC], m_lost[NC], m_filt[NC], m_tog[NC], m_busy[NC];
    logic [TSW-1:0]  m_pts[NC], m_tog_ts[NC];
    int              m_run[NC];
    logic [TSW-1:0]  m_ts = '0;
    longint          m_drops = 0;
    int              m_sel;
    logic [63:0]     m_word;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fq.delete();
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            m_ts = '0;
            m_drops = 0;
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = 0; m_lost[c] = 0; m_filt[c] = 0; m_tog[c] = 0; m_run[c] = 0;
            end
        end else begin
            if ((fq.size() != 0) && m_axis_tready) m_word = fq.pop_front();
            m_sel = -1;
            for (int c = 0; c < NC; c++) begin
                m_busy[c] = m_pend[c];
                if (m_sel < 0 && m_pend[c]) m_sel = c;
            end
            if (m_sel >= 0 && fq.size() < FD) begin
                fq.push_back(mkword(m_lost[m_sel], m_sel, m_pol[m_sel], int'(m_pts[m_sel])));
                m_pend[m_sel] = 0;
                m_lost[m_sel] = 0;
            end
            // A slot counts as occupied for the whole cycle in which its word leaves.
            for (int c = 0; c < NC; c++) begin
                if (m_tog[c] && en && edge_mode[2*c + (m_filt[c] ? 0 : 1)]) begin
                    if (m_busy[c]) begin
                        m_drops++;
                        m_lost[c] = 1;
                    end else begin
                        m_pend[c] = 1;
                        m_pol[c]  = m_filt[c];
                        m_pts[c]  = m_tog_ts[c];
                    end
                end
            end
            m_ts = ts_clear ? '0 : m_ts + 1'b1;
            m_synced = m_hist.pop_front();
            m_hist.push_back(enc_in);
            for (int c = 0; c < NC; c++) begin
                m_tog[c] = 0;
                if (m_run[c] == FL) begin
                    m_filt[c]   = !m_filt[c];
                    m_run[c]    = 0;
                    m_tog[c]    = 1;
                    m_tog_ts[c] = m_ts;
                end else if (m_synced[c] != m_filt[c]) begin
                    m_run[c]++;
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge aclk) begin
        chk("ts_now", 64'(ts_now), 64'(m_ts));
        chk("fifo_level", 64'(fifo_level), 64'(fq.size()));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("tvalid", 64'(m_axis_tvalid), 64'(fq.size() != 0));
        if (fq.size() != 0) chk("tdata", m_axis_tdata, fq[0]);
    end

    logic [TSW-1:0] ev_ts[20];
    int t0;

    initial begin
        tick(3);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_ts", 64'(ts_now), 64'd0);
        aresetn = 1'b1;

        // Single rising edge on ch0: word 8 cycles later, stamped with ts at cycle 6.
        en = 1'b1;
        edge_mode = 8'b0000_0001;
        tick(20);
        t0 = ref_cyc;
        enc_in[0] = 1'b1;
        tick(8);
        chk("t1_not_yet", 64'(m_axis_tvalid), 64'd0);
        tick(1);
        chk("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_word", m_axis_tdata, mkword(0, 0, 1, t0 + 7));
        enc_in[0] = 1'b0;
        tick(20);
        chk("t1_no_fall", 64'(fifo_level), 64'd0);

        // Capture disabled: filter tracks but nothing is queued.
        en = 1'b0;
        enc_in[0] = 1'b1;
        tick(20);
        chk("en0_level", 64'(fifo_level), 64'd0);
        enc_in[0] = 1'b0;
        tick(20);
        en = 1'b1;

        // 3-cycle glitch on ch1 with both polarities enabled.
        edge_mode = 8'b0000_1101;
        enc_in[1] = 1'b1;
        tick(3);
        enc_in[1] = 1'b0;
        tick(20);
        chk("glitch_drop", 64'(drop_count), 64'd0);
        chk("glitch_level", 64'(fifo_level), 64'd0);

        // Simultaneous rising edges: ch0..ch3 in consecutive cycles, same stamp.
        edge_mode = 8'b0101_0101;
        t0 = ref_cyc;
        enc_in = 4'b1111;
        tick(9);
        for (int c = 0; c < NC; c++) begin
            chk("multi_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("multi_word", m_axis_tdata, mkword(0, c, 1, t0 + 7));
            tick(1);
        end
        enc_in = 4'b0000;
        tick(20);
        chk("multi_fall_level", 64'(fifo_level), 64'd0);

        // Backpressure: 20 edges on ch2, FIFO fills, one pending, three dropped.
        edge_mode = 8'b0011_0000;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ev_ts[i] = TSW'(ref_cyc + 7);
            enc_in[2] = ~enc_in[2];
            tick(10);
        end
        tick(10);
        chk("bp_level", 64'(fifo_level), 64'd16);
        chk("bp_drop", 64'(drop_count), 64'd3);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("bp_word", m_axis_tdata, mkword(i == 16, 2, (i % 2) == 0, int'(ev_ts[i])));
            tick(1);
        end
        tick(5);
        chk("bp_empty", 64'(fifo_level), 64'd0);

        // ts_clear loads 0 then counts from 1; stamps follow; 8-bit counter wraps.
        edge_mode = 8'b0000_0001;
        enc_in[0] = 1'b1;
        ts_clear = 1'b1;
        tick(1);
        ts_clear = 1'b0;
        chk("clr_zero", 64'(ts_now), 64'd0);
        tick(1);
        chk("clr_one", 64'(ts_now), 64'd1);
        tick(7);
        chk("clr_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("clr_word", m_axis_tdata, 64'h0100_0000_0000_0006);
        tick(247);
        chk("wrap_255", 64'(ts_now), 64'd255);
        tick(1);
        chk("wrap_0", 64'(ts_now), 64'd0);
        enc_in[0] = 1'b0;
        tick(20);

        // Async reset with 5 words queued and ch1/ch2 pending.
        edge_mode = 8'b1111_1111;
        m_axis_tready = 1'b0;
        enc_in = 4'b1111;
        tick(20);
        chk("rr_level4", 64'(fifo_level), 64'd4);
        enc_in[0] = 1'b0;
        tick(20);
        chk("rr_level5", 64'(fifo_level), 64'd5);
        enc_in[2:1] = 2'b00;
        tick(8);
        chk("rr_level5b", 64'(fifo_level), 64'd5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rr_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rr_level", 64'(fifo_level), 64'd0);
        chk("rr_tdata", m_axis_tdata, 64'd0);
        enc_in = 4'b0000;
        tick(3);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        tick(30);
        chk("rr_no_stale_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rr_no_stale_level", 64'(fifo_level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_edge_timestamper.md
# enc_edge_timestamper

Parametrised multi-channel successor to the single `enc_in` encoder capture path in the Zybo PL design. It takes N_CH asynchronous encoder/sync lines and runs each through a synchroniser and a glitch filter. Every qualifying edge is stamped with a free-running TS_WIDTH counter and queued into a FIFO. Events leave on an AXI4-Stream master toward the PS-side DMA/FIFO reader.

## Interface
- N_CH, 4: number of input channels, 1..64
- TS_WIDTH, 48: timestamp counter width, 8..56
- FILT_LEN, 4: consecutive stable samples needed to accept a level change, 1..255
- FIFO_DEPTH, 16: event FIFO entries, power of 2, ≥2
- aclk  in  1  single clock for the block
- aresetn  in  1  reset, asynchronous assert, active-low
- enc_in  in  N_CH  asynchronous encoder inputs
- en  in  1  capture enable
- edge_mode  in  2*N_CH  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- ts_clear  in  1  synchronous clear of the timestamp counter
- m_axis_tdata  out  64  event word
- m_axis_tvalid  out  1  event available
- m_axis_tready  in  1  downstream accept
- ts_now  out  TS_WIDTH  current counter value
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_count  out  32  dropped-event counter, saturating

## Operation
- Reset values: ts_now=0, tvalid=0, tdata=0, fifo_level=0, drop_count=0, all pending/lost flags=0.
- Synchroniser state and filtered levels reset to 0.
- Sync: each enc_in bit passes a 2-FF synchroniser.
- Filter: a per-channel counter runs while the synced level ≠ the filtered level, and resets to 0 whenever they are equal. When the counter reaches FILT_LEN, the filtered level toggles and the counter clears.
- Edge qualify: a filtered 0→1 is rising and 1→0 is falling. The edge qualifies if en=1 and edge_mode selects that polarity.
- Capture: on a qualifying edge, the channel's pending register latches {polarity, ts_now at that edge}.
- Edge onto busy pending slot: if the channel's pending is already set, the new edge is dropped and the old event is kept. drop_count increments (saturates at 0xFFFFFFFF) and the channel lost flag is set.
- Arbiter: each cycle, if the FIFO is not full, the lowest-index pending channel is written and its pending cleared. Only one write per cycle.
- Full FIFO: a full FIFO stalls pending slots. Nothing is dropped until a channel's second edge arrives.
- Event word layout:
  - [63] lost: copy of the channel lost flag, which clears when the word is written
  - [62:57] channel index
  - [56] polarity, 1 = rising
  - [55:TS_WIDTH] zero
  - [TS_WIDTH-1:0] timestamp
- Timestamp counter: ts_now increments every cycle and wraps modulo 2^TS_WIDTH. ts_clear=1 loads 0 at the next edge, and the count resumes from 1 on the edge after.
- en=0: no new pending entries are created. Filters keep tracking; existing pending entries and FIFO contents still drain.
- edge_mode changes take effect on the next filtered edge.
- Output: first-word-fall-through. tvalid = FIFO non-empty; the head pops when tvalid&&tready.
- Simultaneous push and pop on a full FIFO is allowed; level stays at FIFO_DEPTH.
- Asynchronous reset mid-operation discards all FIFO contents, pending events and filter state; outputs return to reset values immediately.

## Timing
- Cycle 0 is the first aclk edge sampling a new enc_in level held stable. Synced level visible at cycle 2.
- The filtered level toggles at cycle 2+FILT_LEN, and the timestamp equals ts_now at that edge.
- Pending is set at cycle 3+FILT_LEN.
- FIFO write and tvalid=1 occur at cycle 4+FILT_LEN (empty FIFO, no contention).
- Each extra contending lower-index channel adds 1 cycle.
- Pulses shorter than FILT_LEN synced cycles are suppressed entirely.
- tready is sampled at the aclk edge; tdata/tvalid are stable while tvalid=1 and tready=0.
- Sustained throughput is 1 event/cycle.

## Test plan
- Reset, then N_CH=4, FILT_LEN=4, mode 01 on ch0, tready=1; raise enc_in[0] at cycle 0 -> one word at cycle 8 with ch=0, polarity=1, lost=0, timestamp=ts_now at cycle 6. No word on the falling edge.
- 3-cycle pulse on ch1 with FILT_LEN=4, mode 11 -> no event, drop_count=0.
- Rising edge on ch0..ch3 in the same cycle, mode 01 -> four words in consecutive cycles, order ch0,ch1,ch2,ch3, identical timestamps.
- tready=0, FIFO_DEPTH=16, 20 edges on ch2 spaced 10 cycles apart:
  - fifo_level saturates at 16, and the ch2 pending slot holds event 17.
  - Events 18..20 are dropped, drop_count=3.
  - After tready=1: 17 words drain in order, and the 17th word has lost=1.
- TS_WIDTH=8: let ts_now wrap 255->0 and assert ts_clear mid-run -> the counter wraps to 0, ts_clear forces 0 then 1, and edge stamps track ts_now.
- aresetn low while the FIFO holds 5 words and 2 events are pending -> tvalid=0 and fifo_level=0 asynchronously. After release, no stale words are emitted.
